// File: rtl/div_16bit_seq.sv
// Sequential 16-bit restoring divider: start/busy/done handshake, 16 RUN cycles per result.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module div_16bit_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] dvsr_q, dvsr_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] res_quo_q, res_quo_d;
    logic [15:0] res_rem_q, res_rem_d;
    logic        dbz_q, dbz_d;

    logic [16:0] shifted;
    logic        trial_ok;
    logic [15:0] trial_lo;
    logic [15:0] dividend_mag;
    logic [15:0] divisor_mag;
    logic [15:0] fin_quo;
    logic [15:0] fin_rem;

`ifdef DIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    always_comb begin
        dividend_mag = dividend[15] ? (16'd0 - dividend) : dividend;
        divisor_mag  = divisor[15]  ? (16'd0 - divisor)  : divisor;
        fin_quo      = neg_quo_q ? (16'd0 - quo_d) : quo_d;
        fin_rem      = neg_rem_q ? (16'd0 - rem_d) : rem_d;
    end
`else
    always_comb begin
        dividend_mag = dividend;
        divisor_mag  = divisor;
        fin_quo      = quo_d;
        fin_rem      = rem_d;
    end
`endif

    // {partial remainder, next dividend bit} against the divisor; when the trial
    // is non-negative its true value is below the divisor, so the low 16 bits suffice.
    always_comb begin
        shifted  = {rem_q, quo_q[15]};
        trial_ok = (shifted >= {1'b0, dvsr_q});
        trial_lo = shifted[15:0] - dvsr_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvsr_d    = dvsr_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        res_quo_d = res_quo_q;
        res_rem_d = res_rem_q;
        dbz_d     = dbz_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef DIV_SIGNED_EN
                    neg_quo_d = dividend[15] ^ divisor[15];
                    neg_rem_d = dividend[15];
`endif
                    if (divisor == 16'd0) begin
                        state_d   = DONE;
                        res_quo_d = 16'hFFFF;
                        res_rem_d = dividend;
                        dbz_d     = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = 5'd0;
                        rem_d   = 16'd0;
                        quo_d   = dividend_mag;
                        dvsr_d  = divisor_mag;
                    end
                end
            end
            RUN: begin
                // quo_q doubles as the dividend shift register; quotient bits enter at the LSB
                rem_d = trial_ok ? trial_lo : shifted[15:0];
                quo_d = {quo_q[14:0], trial_ok};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d   = DONE;
                    res_quo_d = fin_quo;
                    res_rem_d = fin_rem;
                    dbz_d     = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            dvsr_q    <= 16'd0;
            rem_q     <= 16'd0;
            quo_q     <= 16'd0;
            res_quo_q <= 16'd0;
            res_rem_q <= 16'd0;
            dbz_q     <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvsr_q    <= dvsr_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            res_quo_q <= res_quo_d;
            res_rem_q <= res_rem_d;
            dbz_q     <= dbz_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    always_comb begin
        busy        = (state_q == RUN);
        done        = (state_q == DONE);
        quotient    = res_quo_q;
        remainder   = res_rem_q;
        div_by_zero = dbz_q;
    end

endmodule
